// File: rtl/piso_pkg.sv
// Shared FSM state type and sizing helpers for the parallel-in serial-out transmitter.
// No timing of its own; imported by piso_tx and bit_counter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Per-frame bit counter with a registered count, so last is a pure decode of state.
// One-cycle update after clear/enable; clear wins over enable; no backpressure.
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: first bit one cycle after acceptance, WIDTH bits per frame.
// Backpressure: load_ready only in IDLE or on the last bit, which allows gapless back-to-back frames.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_shift;
  logic             w_accept;
  logic             w_cnt_clr;

  assign w_shift    = (r_state == SHIFT);
  assign load_ready = !w_shift || w_last;
  assign w_accept   = load_valid && load_ready;
  // Clearing on the last bit keeps the counter from ever wrapping, with or without a follow-on word.
  assign w_cnt_clr  = w_accept || (w_shift && w_last);

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_shift),
    .o_count (w_cnt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shreg <= din;
    end else if (w_shift) begin
      if (MSB_FIRST) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
      if (w_last) begin
        r_state <= IDLE;
      end
    end
  end

  // Outputs are decodes of registered state only; din never reaches sout combinationally.
  assign sout       = w_shift && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign sout_valid = w_shift;
  assign busy       = w_shift;
  assign done       = w_shift && (w_cnt == LAST_IDX);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three configurations (8/LSB, 8/MSB, 2/LSB) against a remaining-bits model.
// Directed frames pin the model with literal bit sequences before a randomized run.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din0, din1;
  logic [1:0] din2;
  logic [2:0] lv, rdy, so, sv, bz, dn;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din0), .load_valid(lv[0]), .load_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .din(din1), .load_valid(lv[1]), .load_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
  piso_tx #(.WIDTH(2), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .din(din2), .load_valid(lv[2]), .load_ready(rdy[2]),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

  // Model: a frame is just the captured word and how many of its bits are still to be sent.
  typedef struct {
    int          rem;
    logic [31:0] word;
  } mdl_t;

  mdl_t m0, m1, m2;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int w, input logic v, input logic [31:0] d);
    mdl_t r;
    r = m;
    if (v && m.rem <= 1) begin
      r.word = d;
      r.rem  = w;
    end else if (m.rem > 0) begin
      r.rem = m.rem - 1;
    end
    return r;
  endfunction

  function automatic logic e_sout(input mdl_t m, input int w, input bit msb);
    int k;
    if (m.rem == 0) return 1'b0;
    k = w - m.rem;
    return msb ? m.word[w-1-k] : m.word[k];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0.rem <= 0;
      m1.rem <= 0;
      m2.rem <= 0;
    end else begin
      m0 <= step(m0, 8, lv[0], {24'h0, din0});
      m1 <= step(m1, 8, lv[1], {24'h0, din1});
      m2 <= step(m2, 2, lv[2], {30'h0, din2});
    end
  end

  task automatic cmp(input int i, input mdl_t m, input int w, input bit msb);
    chk($sformatf("sout%0d", i), so[i], e_sout(m, w, msb));
    chk($sformatf("sout_valid%0d", i), sv[i], m.rem > 0);
    chk($sformatf("busy%0d", i), bz[i], m.rem > 0);
    chk($sformatf("done%0d", i), dn[i], m.rem == 1);
    chk($sformatf("load_ready%0d", i), rdy[i], m.rem <= 1);
  endtask

  always @(negedge clk) begin
    cmp(0, m0, 8, 1'b0);
    cmp(1, m1, 8, 1'b1);
    cmp(2, m2, 2, 1'b0);
    if (m0.rem > 0) chk("count0", u0.w_cnt == 3'(8 - m0.rem), 1'b1);
    if (m2.rem > 0) chk("count2", u2.w_cnt == 1'(2 - m2.rem), 1'b1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] a5;
  logic [7:0] x3c;

  initial begin
    a5    = 8'hA5;
    x3c   = 8'h3C;
    reset = 1'b0;
    lv    = 3'b000;
    din0  = 8'h00;
    din1  = 8'h00;
    din2  = 2'b00;
    m0    = '{rem: 0, word: 32'h0};
    m1    = '{rem: 0, word: 32'h0};
    m2    = '{rem: 0, word: 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy[0], 1'b1);
    chk("rst_valid", sv[0], 1'b0);
    chk("rst_sout", so[0], 1'b0);
    chk("rst_done", dn[0], 1'b0);

    // Release reset with words already offered: the first edge must accept them.
    next_cycle();
    din0  = 8'hA5;
    din1  = 8'h80;
    din2  = 2'b10;
    lv    = 3'b111;
    reset = 1'b1;
    next_cycle();
    lv = 3'b000;
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        din0  = 8'hFF;
        lv[0] = 1'b1;
      end else begin
        lv[0] = 1'b0;
      end
      @(negedge clk);
      if (k <= 8) chk("a5_bit", so[0], a5[k-1]);
      else        chk("a5_idle_sout", so[0], 1'b0);
      chk("a5_valid", sv[0], k <= 8);
      chk("a5_done", dn[0], k == 8);
      chk("a5_ready", rdy[0], k >= 8);
      chk("msb80_bit", so[1], k == 1);
      chk("msb80_done", dn[1], k == 8);
      chk("w2_bit", so[2], k == 2);
      chk("w2_valid", sv[2], k <= 2);
      chk("w2_done", dn[2], k == 2);
      next_cycle();
    end
    lv = 3'b000;

    // Back-to-back: the second byte is offered on the first byte's last bit.
    din0  = 8'hA5;
    lv[0] = 1'b1;
    next_cycle();
    for (int k = 1; k <= 17; k++) begin
      if (k == 8) begin
        din0  = 8'h3C;
        lv[0] = 1'b1;
      end else begin
        lv[0] = 1'b0;
      end
      @(negedge clk);
      if (k <= 8)       chk("b2b_bit", so[0], a5[k-1]);
      else if (k <= 16) chk("b2b_bit", so[0], x3c[k-9]);
      else              chk("b2b_idle_sout", so[0], 1'b0);
      chk("b2b_valid", sv[0], k <= 16);
      chk("b2b_done", dn[0], k == 8 || k == 16);
      next_cycle();
    end

    // Asynchronous reset during bit 4 aborts the frame before the next edge.
    din0  = 8'hA5;
    lv[0] = 1'b1;
    next_cycle();
    lv[0] = 1'b0;
    repeat (3) next_cycle();
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", sv[0], 1'b0);
    chk("arst_busy", bz[0], 1'b0);
    chk("arst_done", dn[0], 1'b0);
    chk("arst_ready", rdy[0], 1'b1);
    chk("arst_sout", so[0], 1'b0);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_arst_valid", sv[0], 1'b0);
      chk("post_arst_done", dn[0], 1'b0);
      next_cycle();
    end

    for (int c = 0; c < 3000; c++) begin
      lv[0] = ($urandom_range(0, 3) != 0);
      lv[1] = ($urandom_range(0, 1) != 0);
      lv[2] = ($urandom_range(0, 2) != 0);
      din0  = 8'($urandom);
      din1  = 8'($urandom);
      din2  = 2'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        next_cycle();
      end
    end
    lv = 3'b000;
    repeat (10) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 0, bit order (0 = LSB first, 1 = MSB first).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port load_valid  input  1  din is valid this cycle.
REQ-007 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port sout  output  1  serial data bit.
REQ-009 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 SHALL have port busy  output  1  a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the last bit of a frame.

Function
REQ-012 SHALL implement states IDLE and SHIFT only.
REQ-013 In IDLE: load_ready=1, sout=0, sout_valid=0, busy=0, done=0.
REQ-014 A word SHALL be accepted on any rising edge with load_valid=1 and load_ready=1; din captured into the shift register, bit counter cleared, state -> SHIFT.
REQ-015 Latency: first bit SHALL appear on sout, with sout_valid=1, in the cycle immediately after acceptance.
REQ-016 In SHIFT: sout_valid=1, busy=1; one bit per cycle for exactly WIDTH cycles, order per MSB_FIRST.
REQ-017 Bit counter SHALL be $clog2(WIDTH) bits wide, increment once per SHIFT cycle, and never wrap within a frame.
REQ-018 done=1 SHALL coincide with the cycle carrying bit WIDTH-1 of the frame and be 0 in all other cycles.
REQ-019 load_ready SHALL be 1 in the last-bit cycle of SHIFT and 0 in all other SHIFT cycles.
REQ-020 Word accepted in the last-bit cycle: SHALL remain in SHIFT with counter cleared; next frame's first bit follows the next cycle with no gap.
REQ-021 No acceptance in the last-bit cycle: state -> IDLE on the next edge.
REQ-022 load_valid while load_ready=0 SHALL be ignored; din changes during SHIFT SHALL NOT affect the frame in progress.
REQ-023 busy SHALL equal sout_valid in every cycle.

Reset
REQ-024 reset=0 SHALL immediately, without clk, force state IDLE, shift register 0, counter 0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no done pulse, and no remaining bits are sent after release.
REQ-026 After reset deassertion, a word SHALL be acceptable on the first rising edge.

Structure
REQ-027 State enum (IDLE, SHIFT) SHALL be defined in shared package piso_pkg, with a constant for default WIDTH.
REQ-028 Bit counter SHALL be a separate sub-module bit_counter (clear, enable, count, last flag) parameterised by WIDTH.
REQ-029 All outputs SHALL be driven from registers or state decode only; no combinational path from din to sout.

Verification
REQ-030 WIDTH=8, MSB_FIRST=0, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance; done only on cycle 8; IDLE on cycle 9.
REQ-031 Back-to-back: 8'hA5, then 8'h3C offered on A5's cycle 8 -> 16 contiguous sout_valid cycles, second byte 0,0,1,1,1,1,0,0, done on cycles 8 and 16.
REQ-032 load_valid=1 with din=8'hFF on cycle 3 of an 8'hA5 frame -> ignored; A5 bits unchanged, no extra frame.
REQ-033 reset=0 asynchronously mid-cycle during bit 4 of 8'hA5 -> sout_valid, busy, done drop to 0 before the next edge; load_ready=1; no done pulse.
REQ-034 MSB_FIRST=1, load 8'h80 -> sout 1 on cycle 1, then 0 for cycles 2..8; done on cycle 8.
REQ-035 WIDTH=2, load 2'b10, LSB first -> sout 0 then 1; done on cycle 2; counter never exceeds 1.
